// File: rtl/mips_defs.sv
// Shared definitions for the multiply/divide unit.
// Op and FSM encodings plus the default datapath width.
package mips_defs;

  localparam int WIDTH_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10
  } state_e;

endpackage

// File: rtl/mdu_sign_fix.sv
// Conditional two's-complement negation of a pair of words,
// either as two independent lanes or as one joint {a,b} value.
module mdu_sign_fix #(
  parameter int W = 32
) (
  input  logic         joint,
  input  logic         neg_a,
  input  logic         neg_b,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] ya,
  output logic [W-1:0] yb
);

  logic [2*W-1:0] wide;

  assign wide = {a, b};

  always_comb begin
    ya = a;
    yb = b;
    if (joint) begin
      if (neg_a) {ya, yb} = ~wide + 1'b1;
    end else begin
      if (neg_a) ya = ~a + 1'b1;
      if (neg_b) yb = ~b + 1'b1;
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers.
// Work is done on magnitudes; signs are restored in FIX.
module mul_div_unit
  import mips_defs::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic             mthi,
  input  logic             mtlo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  state_e state, state_nx;
  op_e    op_q;
  logic   sa_q, sb_q;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi, acc_lo, opnd;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [WIDTH-1:0] res_hi, res_lo;
  logic [WIDTH:0]   sum, shifted, diff;

  logic in_signed, in_mul, is_mul, last;
  logic fix_neg_hi, fix_neg_lo;

  assign in_signed = (op_e'(op) == OP_MULT) ||
                     (op_e'(op) == OP_DIV);
  assign in_mul    = (op_e'(op) == OP_MULT) ||
                     (op_e'(op) == OP_MULTU);
  assign is_mul    = (op_q == OP_MULT) ||
                     (op_q == OP_MULTU);
  assign last      = cnt == CW'(WIDTH - 1);
  assign busy      = state != IDLE;

  mdu_sign_fix #(.W(WIDTH)) u_opnd (
    .joint (1'b0),
    .neg_a (in_signed & src_a[WIDTH-1]),
    .neg_b (in_signed & src_b[WIDTH-1]),
    .a     (src_a),
    .b     (src_b),
    .ya    (mag_a),
    .yb    (mag_b)
  );

  // Divide by zero keeps the all-ones quotient unsigned.
  assign fix_neg_hi = is_mul ? (sa_q ^ sb_q) : sa_q;
  assign fix_neg_lo = (sa_q ^ sb_q) & (opnd != '0);

  mdu_sign_fix #(.W(WIDTH)) u_res (
    .joint (is_mul),
    .neg_a (fix_neg_hi),
    .neg_b (fix_neg_lo),
    .a     (acc_hi),
    .b     (acc_lo),
    .ya    (res_hi),
    .yb    (res_lo)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (start) state_nx = RUN;
      RUN:     if (last) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign sum     = {1'b0, acc_hi} +
                   (acc_lo[0] ? {1'b0, opnd} : '0);
  assign shifted = {acc_hi, acc_lo[WIDTH-1]};
  assign diff    = shifted - {1'b0, opnd};

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q   <= OP_MULT;
      sa_q   <= 1'b0;
      sb_q   <= 1'b0;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      done   <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            op_q   <= op_e'(op);
            sa_q   <= in_signed & src_a[WIDTH-1];
            sb_q   <= in_signed & src_b[WIDTH-1];
            cnt    <= '0;
            acc_hi <= '0;
            acc_lo <= in_mul ? mag_b : mag_a;
            opnd   <= in_mul ? mag_a : mag_b;
          end else begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
          end
        end
        RUN: begin
          cnt <= cnt + CW'(1);
          if (is_mul) begin
            acc_hi <= sum[WIDTH:1];
            acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
          end else if (diff[WIDTH]) begin
            acc_hi <= shifted[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
          end else begin
            acc_hi <= diff[WIDTH-1:0];
            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
          end
        end
        FIX: begin
          hi   <= res_hi;
          lo   <= res_lo;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: directed corners plus
// random ops checked against a plain-arithmetic model.
module tb_mul_div_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a, src_b, wdata;
  logic        mthi, mtlo;
  logic        busy, done;
  logic [31:0] hi, lo;

  logic [63:0] sb[$];
  logic [63:0] exp_v;
  logic [31:0] cur_hi, cur_lo;
  int          n_vec = 0;
  int          n_err = 0;

  mul_div_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .op    (op),
    .src_a (src_a),
    .src_b (src_b),
    .mthi  (mthi),
    .mtlo  (mtlo),
    .wdata (wdata),
    .busy  (busy),
    .done  (done),
    .hi    (hi),
    .lo    (lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic [1:0] o,
                                        input logic [31:0] a,
                                        input logic [31:0] b);
    longint sa, sbv, q, r;
    logic [63:0] p;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    case (o)
      2'd0: p = sa * sbv;
      2'd1: p = {32'd0, a} * {32'd0, b};
      2'd2: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else begin
          q = sa / sbv;
          r = sa % sbv;
          p = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 0) p = {a, 32'hFFFFFFFF};
        else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFFFFFF;
      3: return 32'h80000000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  always @(negedge clk) begin
    if (!rst && done) begin
      if (sb.size() == 0) begin
        chk("spurious_done", 64'(sb.size()), 64'd1);
      end else begin
        exp_v = sb.pop_front();
        chk("result", {hi, lo}, exp_v);
      end
    end
  end

  task automatic wait_idle();
    int i = 0;
    while (busy && i < 100) begin
      @(negedge clk);
      i++;
    end
    chk("idle_wait", 64'(busy), 64'd0);
  endtask

  task automatic run_op(input logic [1:0] o,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input bit disturb,
                        input bit with_move);
    logic [63:0] e;
    int lat, ndone;
    bit busy_ok, hold_ok;
    wait_idle();
    @(negedge clk);
    start = 1'b1;
    op    = o;
    src_a = a;
    src_b = b;
    if (with_move) begin
      mthi  = 1'b1;
      mtlo  = 1'b1;
      wdata = 32'h55555555;
    end
    e = model(o, a, b);
    @(posedge clk);
    #1;
    start = 1'b0;
    mthi  = 1'b0;
    mtlo  = 1'b0;
    op    = 2'($urandom);
    src_a = $urandom;
    src_b = $urandom;
    sb.push_back(e);
    busy_ok = busy;
    hold_ok = (hi === cur_hi) && (lo === cur_lo);
    lat   = 0;
    ndone = 0;
    for (int k = 1; k <= 36; k++) begin
      @(posedge clk);
      #1;
      if (k == 6 && disturb) begin
        start = 1'b0;
        mthi  = 1'b0;
      end
      if (done) begin
        ndone++;
        if (lat == 0) lat = k;
      end
      if (k < 33) begin
        if (!busy) busy_ok = 0;
        if (hi !== cur_hi || lo !== cur_lo) hold_ok = 0;
      end
      if (k >= 33 && busy) busy_ok = 0;
      if (k == 5 && disturb) begin
        start = 1'b1;
        op    = 2'd1;
        src_a = $urandom;
        src_b = $urandom;
        mthi  = 1'b1;
        wdata = 32'hAAAAAAAA;
      end
    end
    chk("latency", 64'(lat), 64'd33);
    chk("done_pulse", 64'(ndone), 64'd1);
    chk("busy_window", 64'(busy_ok), 64'd1);
    chk("hilo_hold", 64'(hold_ok), 64'd1);
    cur_hi = e[63:32];
    cur_lo = e[31:0];
  endtask

  initial begin
    rst    = 1'b1;
    start  = 1'b0;
    op     = 2'd0;
    src_a  = '0;
    src_b  = '0;
    mthi   = 1'b0;
    mtlo   = 1'b0;
    wdata  = '0;
    cur_hi = '0;
    cur_lo = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hilo", {hi, lo}, 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    run_op(2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 0);
    run_op(2'd0, 32'hFFFFFFFD, 32'h00000007, 0, 0);
    run_op(2'd0, 32'h80000000, 32'h80000000, 0, 0);
    run_op(2'd2, 32'hFFFFFFF9, 32'h00000002, 0, 0);
    run_op(2'd3, 32'h00000007, 32'h00000002, 0, 0);
    run_op(2'd2, 32'h12345678, 32'h00000000, 0, 0);
    run_op(2'd2, 32'hF0000001, 32'h00000000, 0, 0);
    run_op(2'd2, 32'h80000000, 32'hFFFFFFFF, 0, 0);
    run_op(2'd0, 32'h00001234, 32'h00005678, 1, 0);

    @(negedge clk);
    mtlo  = 1'b1;
    wdata = 32'hDEADBEEF;
    @(posedge clk);
    #1;
    mtlo = 1'b0;
    chk("mtlo_lo", 64'(lo), 64'hDEADBEEF);
    chk("mtlo_hi", 64'(hi), 64'(cur_hi));
    cur_lo = 32'hDEADBEEF;

    @(negedge clk);
    mthi  = 1'b1;
    mtlo  = 1'b1;
    wdata = 32'h13579BDF;
    @(posedge clk);
    #1;
    mthi = 1'b0;
    mtlo = 1'b0;
    chk("mt_both", {hi, lo}, {2{32'h13579BDF}});
    cur_hi = 32'h13579BDF;
    cur_lo = 32'h13579BDF;

    run_op(2'd3, 32'h00000064, 32'h00000007, 0, 1);

    @(negedge clk);
    start = 1'b1;
    op    = 2'd3;
    src_a = 32'h00010000;
    src_b = 32'h00000007;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_hilo", {hi, lo}, 64'd0);
    cur_hi = '0;
    cur_lo = '0;

    run_op(2'd1, 32'd3, 32'd5, 0, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(2'($urandom_range(0, 3)), pick(), pick(), 0, 0);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("queue_empty", 64'(sb.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
